monitor_event_capture: RTL and testbench

//  Multi-channel successor to the single-channel monitor/strobe block. It registers NUM_CH data

---
 rtl/monitor_event_capture_pkg.sv | 35 +++
 rtl/monitor_event_capture_fifo.sv | 55 +++++
 rtl/monitor_event_capture.sv | 222 ++++++++++++++++++++++
 tb/tb_monitor_event_capture.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/monitor_event_capture_pkg.sv
// Shared types for monitor_event_capture: event kind encoding, the queued event record and the
// saturating lost-event counter helper. Record fields are sized for the largest supported build.
package monitor_pkg;

    localparam int EVT_CH_MAX_W    = 8;
    localparam int EVT_DATA_MAX_W  = 32;
    localparam int EVT_STAMP_MAX_W = 32;
    localparam logic [7:0] OVF_MAX = 8'hFF;

    typedef enum logic {
        EVT_CHANGE = 1'b0,
        EVT_CROSS  = 1'b1
    } evt_kind_e;

    typedef struct packed {
        logic [EVT_CH_MAX_W-1:0]    ch;
        evt_kind_e                  kind;
        logic [EVT_DATA_MAX_W-1:0]  data;
        logic [EVT_STAMP_MAX_W-1:0] stamp;
    } mon_event_t;

    localparam int EVT_W = $bits(mon_event_t);

    // Adds inc to cnt, clamping at OVF_MAX instead of wrapping.
    function automatic logic [7:0] ovf_sat_add(input logic [7:0] cnt, input logic [7:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {1'b0, inc};
        if (sum > {1'b0, OVF_MAX}) begin
            return OVF_MAX;
        end else begin
            return sum[7:0];
        end
    endfunction

endpackage

// File: rtl/monitor_event_capture_fifo.sv
// mon_event_fifo: show-ahead FIFO of packed mon_event_t records. The head entry is visible on
// dout whenever empty is low; a push while full is accepted only alongside a pop.
module mon_event_fifo
    import monitor_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [EVT_W-1:0] din,
    input  logic             pop,
    output logic [EVT_W-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [EVT_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices meet.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Read/write pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array; contents behind the pointers are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/monitor_event_capture.sv
// monitor_event_capture: passive multi-channel change / upward-threshold-crossing monitor with
// timestamped event queue. Define MONITOR_EVENT_DISPLAY_EN to print pushes and overflows.
module monitor_event_capture
    import monitor_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int DATA_W     = 8,
    parameter  int FIFO_DEPTH = 8,
    parameter  int STAMP_W    = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk_monitor,
    input  logic                     rst_monitor,
    input  logic [NUM_CH*DATA_W-1:0] data_in_monitor,
    input  logic [NUM_CH-1:0]        enable_monitor,
    input  logic [DATA_W-1:0]        threshold,
    output logic [NUM_CH*DATA_W-1:0] data_out_monitor,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [CH_W-1:0]          evt_ch,
    output logic                     evt_kind,
    output logic [DATA_W-1:0]        evt_data,
    output logic [STAMP_W-1:0]       evt_stamp,
    output logic [7:0]               overflow_cnt
);

    logic                primed;
    logic [STAMP_W-1:0]  stamp;
    logic [DATA_W-1:0]   lane_in   [NUM_CH];
    logic [DATA_W-1:0]   lane_prev [NUM_CH];
    logic [NUM_CH-1:0]   det_vld;
    evt_kind_e           det_kind  [NUM_CH];
    logic [NUM_CH-1:0]   slot_vld;
    evt_kind_e           slot_kind  [NUM_CH];
    logic [DATA_W-1:0]   slot_data  [NUM_CH];
    logic [STAMP_W-1:0]  slot_stamp [NUM_CH];
    logic [CH_W-1:0]     rr_start;
    logic                grant_vld;
    logic [CH_W-1:0]     grant_ch;
    logic [NUM_CH-1:0]   grant_hit;
    logic [NUM_CH-1:0]   ovf_hit;
    logic [7:0]          ovf_inc;
    mon_event_t          push_evt;
    mon_event_t          head_evt;
    logic [EVT_W-1:0]    fifo_din;
    logic [EVT_W-1:0]    fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic                unused_head_bits;

    // Channel index offset from base, wrapping at NUM_CH (NUM_CH need not be a power of 2).
    function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int off);
        int sum;
        sum = (int'(base) + off) % NUM_CH;
        return CH_W'(sum);
    endfunction

    // Split the flat buses into per-channel lanes.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            lane_in[c]   = data_in_monitor[c*DATA_W +: DATA_W];
            lane_prev[c] = data_out_monitor[c*DATA_W +: DATA_W];
        end
    end

    // Pass-through delay, priming flag and free-running timestamp.
    always_ff @(posedge clk_monitor) begin
        if (rst_monitor) begin
            data_out_monitor <= '0;
            primed           <= 1'b0;
            stamp            <= '0;
        end else begin
            data_out_monitor <= data_in_monitor;
            primed           <= 1'b1;
            stamp            <= stamp + STAMP_W'(1);
        end
    end

    // Per-channel detection; a crossing takes precedence over a plain change.
    always_comb begin
        det_vld = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            det_kind[c] = EVT_CHANGE;
            if (primed && enable_monitor[c]) begin
                if ((lane_in[c] > threshold) && (lane_prev[c] <= threshold)) begin
                    det_vld[c]  = 1'b1;
                    det_kind[c] = EVT_CROSS;
                end else if (lane_in[c] != lane_prev[c]) begin
                    det_vld[c]  = 1'b1;
                end else begin
                    det_vld[c]  = 1'b0;
                end
            end else begin
                det_vld[c] = 1'b0;
            end
        end
    end

    // Round-robin pick of the first occupied slot at or after rr_start; none while the FIFO is full.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!grant_vld && !fifo_full && slot_vld[rr_idx(rr_start, i)]) begin
                grant_vld = 1'b1;
                grant_ch  = rr_idx(rr_start, i);
            end else begin
                grant_vld = grant_vld;
            end
        end
    end

    // A write into an occupied, ungranted slot loses the older event.
    always_comb begin
        ovf_inc = 8'd0;
        for (int c = 0; c < NUM_CH; c++) begin
            grant_hit[c] = grant_vld && (grant_ch == CH_W'(c));
            ovf_hit[c]   = det_vld[c] && slot_vld[c] && !grant_hit[c];
            ovf_inc      = ovf_inc + 8'(ovf_hit[c]);
        end
    end

    // Pending slots: a new detection always wins over the grant clearing the slot.
    always_ff @(posedge clk_monitor) begin
        if (rst_monitor) begin
            slot_vld <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                slot_kind[c]  <= EVT_CHANGE;
                slot_data[c]  <= '0;
                slot_stamp[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (det_vld[c]) begin
                    slot_vld[c]   <= 1'b1;
                    slot_kind[c]  <= det_kind[c];
                    slot_data[c]  <= lane_in[c];
                    slot_stamp[c] <= stamp;
                end else if (grant_hit[c]) begin
                    slot_vld[c]   <= 1'b0;
                end
            end
        end
    end

    // Arbiter pointer and lost-event counter.
    always_ff @(posedge clk_monitor) begin
        if (rst_monitor) begin
            rr_start     <= '0;
            overflow_cnt <= 8'd0;
        end else begin
            if (grant_vld) begin
                rr_start <= rr_idx(grant_ch, 1);
            end
            overflow_cnt <= ovf_sat_add(overflow_cnt, ovf_inc);
        end
    end

    // Assemble the granted slot into a queue record.
    always_comb begin
        push_evt       = '0;
        push_evt.ch    = EVT_CH_MAX_W'(grant_ch);
        push_evt.kind  = slot_kind[grant_ch];
        push_evt.data  = EVT_DATA_MAX_W'(slot_data[grant_ch]);
        push_evt.stamp = EVT_STAMP_MAX_W'(slot_stamp[grant_ch]);
    end

    assign fifo_din = push_evt;
    assign fifo_pop = evt_valid && evt_ready;

    mon_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_monitor),
        .rst   (rst_monitor),
        .push  (grant_vld),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_evt         = mon_event_t'(fifo_dout);
    assign unused_head_bits = ^{head_evt.ch, head_evt.data, head_evt.stamp};

    // Head fields are forced to zero while the queue is empty.
    always_comb begin
        evt_valid = !fifo_empty;
        if (fifo_empty) begin
            evt_ch    = '0;
            evt_kind  = 1'b0;
            evt_data  = '0;
            evt_stamp = '0;
        end else begin
            evt_ch    = head_evt.ch[CH_W-1:0];
            evt_kind  = head_evt.kind;
            evt_data  = head_evt.data[DATA_W-1:0];
            evt_stamp = head_evt.stamp[STAMP_W-1:0];
        end
    end

`ifdef MONITOR_EVENT_DISPLAY_EN
    mon_event_t trace_evt;

    // Trace of queue pushes and lost events; trace_evt holds the pushed record when $strobe fires.
    always_ff @(posedge clk_monitor) begin
        if (!rst_monitor && grant_vld) begin
            trace_evt <= push_evt;
            $strobe("monitor_event_capture: ch=%0d kind=%s data=%0d stamp=%0d", trace_evt.ch,
                    (trace_evt.kind == EVT_CROSS) ? "CROSS" : "CHANGE", trace_evt.data,
                    trace_evt.stamp);
        end
        if (!rst_monitor && (ovf_inc != 8'd0) && (overflow_cnt != OVF_MAX)) begin
            $display("monitor_event_capture: overflow_cnt %0d -> %0d", overflow_cnt,
                     ovf_sat_add(overflow_cnt, ovf_inc));
        end
    end
`endif

endmodule

// File: tb/tb_monitor_event_capture.sv
// Directed self-checking bench for monitor_event_capture (default parameters).
module tb_monitor_event_capture;

    logic        clk;
    logic        rst;
    logic [31:0] din;
    logic [3:0]  en;
    logic [7:0]  thr;
    logic [31:0] dout;
    logic        evt_valid;
    logic        evt_ready;
    logic [1:0]  evt_ch;
    logic        evt_kind;
    logic [7:0]  evt_data;
    logic [15:0] evt_stamp;
    logic [7:0]  overflow_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    monitor_event_capture dut (
        .clk_monitor      (clk),
        .rst_monitor      (rst),
        .data_in_monitor  (din),
        .enable_monitor   (en),
        .threshold        (thr),
        .data_out_monitor (dout),
        .evt_valid        (evt_valid),
        .evt_ready        (evt_ready),
        .evt_ch           (evt_ch),
        .evt_kind         (evt_kind),
        .evt_data         (evt_data),
        .evt_stamp        (evt_stamp),
        .overflow_cnt     (overflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // After return the bench is in cycle 0 after release, where the stamp counter holds 0.
    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        din = 32'd0; en = 4'hF; thr = 8'hFF; evt_ready = 1'b0;
        do_reset();
        total++;
        if (dout !== 32'd0) begin bad++; $display("FAIL rst_dout: got %0h want 0", dout); end
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", evt_valid); end
        total++;
        if (overflow_cnt !== 8'd0) begin bad++; $display("FAIL rst_ovf: got %0d want 0", overflow_cnt); end
        total++;
        if ({evt_ch, evt_kind, evt_data, evt_stamp} !== 27'd0) begin
            bad++; $display("FAIL rst_head: got %0h want 0", {evt_ch, evt_kind, evt_data, evt_stamp});
        end
    endtask

    task automatic test_change();
        din = 32'd5; en = 4'b0001; thr = 8'hFF; evt_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (evt_valid !== 1'b0) begin bad++; $display("FAIL prime_noevt: cyc %0d got %0b want 0", cyc, evt_valid); end
        end
        din[7:0] = 8'd6;
        tick();
        evt_ready = 1'b1;
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL chg_early: got %0b want 0", evt_valid); end
        tick();
        evt_ready = 1'b0;
        total++;
        if (evt_valid !== 1'b1) begin bad++; $display("FAIL chg_valid: got %0b want 1", evt_valid); end
        total++;
        if ({evt_ch, evt_kind, evt_data, evt_stamp} !== {2'd0, 1'b0, 8'd6, 16'd3}) begin
            bad++; $display("FAIL chg_head: got ch=%0d k=%0d d=%0d s=%0d want ch=0 k=0 d=6 s=3",
                            evt_ch, evt_kind, evt_data, evt_stamp);
        end
        total++;
        if (dout[7:0] !== 8'd6) begin bad++; $display("FAIL chg_dout: got %0d want 6", dout[7:0]); end
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL chg_drain: got %0b want 0", evt_valid); end
    endtask

    task automatic test_cross();
        logic       exp_kind [3];
        logic [7:0] exp_data [3];
        exp_kind = '{1'b1, 1'b0, 1'b0};
        exp_data = '{8'd101, 8'd102, 8'd50};
        din = 32'd0; din[15:8] = 8'd100; en = 4'b0010; thr = 8'd100; evt_ready = 1'b0;
        do_reset();
        tick();
        tick();
        din[15:8] = 8'd101;
        din[7:0]  = 8'd33;
        tick();
        din[15:8] = 8'd102;
        tick();
        din[15:8] = 8'd50;
        tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({evt_valid, evt_ch, evt_kind, evt_data, evt_stamp} !==
                {1'b1, 2'd1, exp_kind[i], exp_data[i], 16'(2 + i)}) begin
                bad++; $display("FAIL cross_evt%0d: got v=%0b ch=%0d k=%0d d=%0d s=%0d want v=1 ch=1 k=%0d d=%0d s=%0d",
                                i, evt_valid, evt_ch, evt_kind, evt_data, evt_stamp, exp_kind[i], exp_data[i], 2 + i);
            end
            evt_ready = 1'b1;
            tick();
            evt_ready = 1'b0;
        end
        tick();
        tick();
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL cross_extra: got %0b want 0", evt_valid); end
    endtask

    task automatic test_all_channels();
        din = 32'd0; en = 4'hF; thr = 8'hFF; evt_ready = 1'b0;
        do_reset();
        tick();
        tick();
        din = 32'h13121110;
        evt_ready = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({evt_valid, evt_ch, evt_kind, evt_data, evt_stamp} !==
                {1'b1, 2'(i), 1'b0, 8'(8'h10 + i), 16'd2}) begin
                bad++; $display("FAIL allch_evt%0d: got v=%0b ch=%0d k=%0d d=%0h s=%0d want v=1 ch=%0d k=0 d=%0h s=2",
                                i, evt_valid, evt_ch, evt_kind, evt_data, evt_stamp, i, 8'h10 + i);
            end
            tick();
        end
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL allch_extra: got %0b want 0", evt_valid); end
        evt_ready = 1'b0;
    endtask

    task automatic test_overflow();
        int order [9];
        order = '{0, 1, 2, 3, 4, 5, 6, 7, 11};
        din = 32'd0; en = 4'b0100; thr = 8'hFF; evt_ready = 1'b0;
        do_reset();
        tick();
        tick();
        for (int i = 0; i < 12; i++) begin
            din[23:16] = (i % 2 == 0) ? 8'h11 : 8'h00;
            tick();
        end
        tick();
        tick();
        tick();
        total++;
        if (overflow_cnt !== 8'd3) begin bad++; $display("FAIL ovf_cnt: got %0d want 3", overflow_cnt); end
        for (int j = 0; j < 9; j++) begin
            total++;
            if ({evt_valid, evt_ch, evt_data, evt_stamp} !==
                {1'b1, 2'd2, ((order[j] % 2 == 0) ? 8'h11 : 8'h00), 16'(2 + order[j])}) begin
                bad++; $display("FAIL ovf_drain%0d: got v=%0b ch=%0d d=%0h s=%0d want v=1 ch=2 d=%0h s=%0d",
                                j, evt_valid, evt_ch, evt_data, evt_stamp,
                                (order[j] % 2 == 0) ? 8'h11 : 8'h00, 2 + order[j]);
            end
            evt_ready = 1'b1;
            tick();
            evt_ready = 1'b0;
        end
        tick();
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty: got %0b want 0", evt_valid); end
        total++;
        if (overflow_cnt !== 8'd3) begin bad++; $display("FAIL ovf_hold: got %0d want 3", overflow_cnt); end
    endtask

    // Continues from test_overflow without a reset so the lost-event count is non-zero.
    task automatic test_reset_mid();
        en = 4'b0111; thr = 8'hFF; evt_ready = 1'b0;
        din = 32'h00030201;
        tick();
        tick();
        tick();
        tick();
        total++;
        if ({evt_valid, evt_ch, evt_data} !== {1'b1, 2'd0, 8'd1}) begin
            bad++; $display("FAIL mid_pre: got v=%0b ch=%0d d=%0d want v=1 ch=0 d=1", evt_valid, evt_ch, evt_data);
        end
        rst = 1'b1;
        tick();
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %0b want 0", evt_valid); end
        total++;
        if (overflow_cnt !== 8'd0) begin bad++; $display("FAIL mid_ovf: got %0d want 0", overflow_cnt); end
        total++;
        if (dout !== 32'd0) begin bad++; $display("FAIL mid_dout: got %0h want 0", dout); end
        rst = 1'b0;
        din = 32'd0;
        tick();
        tick();
        tick();
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL mid_after: got %0b want 0", evt_valid); end
    endtask

    task automatic test_stamp_wrap();
        din = 32'd0; en = 4'b0001; thr = 8'hFF; evt_ready = 1'b0;
        do_reset();
        while (cyc < 65535) tick();
        din[7:0] = 8'd1;
        tick();
        din[7:0] = 8'd2;
        tick();
        total++;
        if ({evt_valid, evt_data, evt_stamp} !== {1'b1, 8'd1, 16'hFFFF}) begin
            bad++; $display("FAIL wrap_max: got v=%0b d=%0d s=%0h want v=1 d=1 s=ffff", evt_valid, evt_data, evt_stamp);
        end
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        total++;
        if ({evt_valid, evt_data, evt_stamp} !== {1'b1, 8'd2, 16'h0000}) begin
            bad++; $display("FAIL wrap_zero: got v=%0b d=%0d s=%0h want v=1 d=2 s=0", evt_valid, evt_data, evt_stamp);
        end
    endtask

    initial begin
        rst = 1'b1; din = 32'd0; en = 4'd0; thr = 8'd0; evt_ready = 1'b0;
        test_reset();
        test_change();
        test_cross();
        test_all_channels();
        test_overflow();
        test_reset_mid();
        test_stamp_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
